// File: rtl/qed_inst_pkg.sv
// Shared encodings for the QED legal-instruction generator: opcodes, funct7 values,
// instruction classes, generator FSM states and the LFSR tap mask.
package qed_inst_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_NOP   = 7'b1111111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [31:0] LFSR_TAPS = 32'hA300_0000;

   typedef enum logic [1:0] {
      CLS_R   = 2'b00,
      CLS_MUL = 2'b01,
      CLS_I   = 2'b10,
      CLS_MEM = 2'b11
   } inst_cls_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } gen_state_e;

   // Galois right shift; a non-zero state never maps to zero.
   function automatic logic [31:0] lfsr_step(input logic [31:0] r);
      return {1'b0, r[31:1]} ^ (r[0] ? LFSR_TAPS : 32'h0);
   endfunction

endpackage

// File: rtl/qed_inst_enc.sv
// Combinational map from an LFSR state to a legal RV32IM word (x0-x15 only).
// QED_INST_GEN_NOP_EN: states with r[31:28]==4'hF emit the stall NOP instead.
module qed_inst_enc
   import qed_inst_pkg::*;
(
   input  logic [31:0] r,
   output logic [31:0] inst
);

   logic [4:0]  rd, rs1, rs2, imm5;
   logic [2:0]  f3;
   logic [6:0]  f7;
   inst_cls_e   cls;
   logic        unused_hi;

   assign rd        = {1'b0, r[9:6]};
   assign rs1       = {1'b0, r[13:10]};
   assign rs2       = {1'b0, r[17:14]};
   assign f3        = r[4:2];
   assign imm5      = r[22:18];
   assign cls       = inst_cls_e'(r[1:0]);
   assign unused_hi = ^r[31:30];

   always_comb begin
      inst = 32'h0;
      f7   = F7_BASE;
      case (cls)
         CLS_R: begin
            if (r[5] && (f3 == 3'b000 || f3 == 3'b101)) f7 = F7_ALT;
            inst = {f7, rs2, rs1, f3, rd, OP_R};
         end
         CLS_MUL: inst = {F7_MULDIV, rs2, rs1, {1'b0, r[3:2]}, rd, OP_R};
         CLS_I: begin
            // Shifts carry a 5-bit shamt; only SRAI may set the alt funct7 bit.
            if (f3 == 3'b001)      inst = {F7_BASE, imm5, rs1, f3, rd, OP_I};
            else if (f3 == 3'b101) inst = {1'b0, r[5], 5'b00000, imm5, rs1, f3, rd, OP_I};
            else                   inst = {r[29:18], rs1, f3, rd, OP_I};
         end
         CLS_MEM: begin
            if (!r[2]) inst = {7'b0, imm5, 5'b0, 3'b010, rd, OP_LOAD};
            else       inst = {7'b0, 5'b0, rs1, 3'b010, imm5, OP_STORE};
         end
         default: inst = 32'h0;
      endcase
`ifdef QED_INST_GEN_NOP_EN
      if (r[31:28] == 4'hF) inst = {25'b0, OP_NOP};
`endif
   end

endmodule

// File: rtl/qed_inst_gen.sv
// LFSR-driven legal instruction source with valid/ready output, issue counter and
// optional instruction budget. QED_INST_GEN_NOP_EN is honoured inside qed_inst_enc.
module qed_inst_gen
   import qed_inst_pkg::*;
#(
   parameter logic [31:0] SEED      = 32'h0000_0001,
   parameter int          NUM_INSTS = 0,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [31:0]      out_inst,
   output logic [CNT_W-1:0] inst_count,
   output logic             done,
   output logic [1:0]       dbg_state
);

   localparam logic [31:0]      SEED_EFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
   localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(NUM_INSTS);
   localparam bit               LIMITED  = (NUM_INSTS != 0);

   gen_state_e       state, state_next;
   logic [31:0]      lfsr;
   logic [CNT_W-1:0] count_inc;
   logic             hs;

   // Handshake: a word transfers on a cycle with out_valid & out_ready. Once raised,
   // out_valid stays high and out_inst stays stable until that transfer happens.
   assign hs        = out_valid & out_ready;
   assign count_inc = (inst_count == '1) ? inst_count : inst_count + CNT_W'(1);
   assign dbg_state = state;

   qed_inst_enc u_enc (
      .r    (lfsr),
      .inst (out_inst)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (en) state_next = ST_ISSUE;
         ST_ISSUE: begin
            if (hs) begin
               if (LIMITED && count_inc == LIMIT) state_next = ST_DONE;
               else if (!en)                      state_next = ST_IDLE;
            end
         end
         ST_DONE:  state_next = ST_DONE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state == ST_ISSUE);
      done      = (state == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr       <= SEED_EFF;
         inst_count <= '0;
      end else if (hs) begin
         lfsr       <= lfsr_step(lfsr);
         inst_count <= count_inc;
      end
   end

endmodule

// File: tb/tb_qed_inst_gen.sv
// Bench for qed_inst_gen: directed start/stall/budget/saturation/reset steps plus a
// randomized run checked against an arithmetic reference encoder and a decoder.
module tb_qed_inst_gen;
   import qed_inst_pkg::*;

   logic        clk = 1'b0;
   logic        rst, en, out_ready;

   logic        a_valid, b_valid, c_valid, a_done, b_done, c_done;
   logic [31:0] a_inst, b_inst, c_inst;
   logic [15:0] a_count, b_count;
   logic [2:0]  c_count;
   logic [1:0]  a_state, b_state, c_state;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_hs    = 0;
   int          n_nop   = 0;

   // behavioural model of instance A
   logic [31:0] m_lfsr;
   bit          m_valid;
   int          m_count;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   qed_inst_gen #(.SEED(32'h1), .NUM_INSTS(0), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .en(en), .out_ready(out_ready), .out_valid(a_valid),
      .out_inst(a_inst), .inst_count(a_count), .done(a_done), .dbg_state(a_state));

   qed_inst_gen #(.SEED(32'h0), .NUM_INSTS(4), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .en(en), .out_ready(out_ready), .out_valid(b_valid),
      .out_inst(b_inst), .inst_count(b_count), .done(b_done), .dbg_state(b_state));

   qed_inst_gen #(.SEED(32'h1), .NUM_INSTS(0), .CNT_W(3)) dut_c (
      .clk(clk), .rst(rst), .en(en), .out_ready(out_ready), .out_valid(c_valid),
      .out_inst(c_inst), .inst_count(c_count), .done(c_done), .dbg_state(c_state));

   function automatic logic [31:0] ref_next(input logic [31:0] r);
      return (r >> 1) ^ ((r % 2 == 1) ? 32'hA300_0000 : 32'h0);
   endfunction

   function automatic logic [31:0] lfsr_n(input logic [31:0] seed, input int n);
      logic [31:0] r = seed;
      for (int i = 0; i < n; i++) r = ref_next(r);
      return r;
   endfunction

   function automatic logic [31:0] ref_enc(input logic [31:0] r);
      int unsigned v, cls, rd, rs1, rs2, f3, b5, imm5, imm12, w;
      v     = r;
      cls   = v % 4;
      f3    = (v / 4) % 8;
      b5    = (v / 32) % 2;
      rd    = (v / 64) % 16;
      rs1   = (v / 1024) % 16;
      rs2   = (v / 16384) % 16;
      imm5  = (v / 262144) % 32;
      imm12 = (v / 262144) % 4096;
      w     = 0;
      case (cls)
         0: w = ((b5 == 1 && (f3 == 0 || f3 == 5)) ? 32'h4000_0000 : 32'h0) + rs2 * 1048576
                + rs1 * 32768 + f3 * 4096 + rd * 128 + 51;
         1: w = 33554432 + rs2 * 1048576 + rs1 * 32768 + (f3 % 4) * 4096 + rd * 128 + 51;
         2: begin
            if (f3 == 1)      w = imm5 * 1048576 + rs1 * 32768 + 4096 + rd * 128 + 19;
            else if (f3 == 5) w = b5 * 32'h4000_0000 + imm5 * 1048576 + rs1 * 32768 + 5 * 4096 + rd * 128 + 19;
            else              w = imm12 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 19;
         end
         default: begin
            if (f3 % 2 == 0) w = imm5 * 1048576 + 2 * 4096 + rd * 128 + 3;
            else             w = rs1 * 32768 + 2 * 4096 + imm5 * 128 + 35;
         end
      endcase
`ifdef QED_INST_GEN_NOP_EN
      if (v / 268435456 == 15) w = 127;
`endif
      return w;
   endfunction

   // Independent legality decoder for any emitted word.
   function automatic bit legal(input logic [31:0] w);
      logic [6:0] op, f7;
      logic [4:0] rd, rs1, rs2;
      logic [2:0] f3;
      op = w[6:0]; rd = w[11:7]; f3 = w[14:12]; rs1 = w[19:15]; rs2 = w[24:20]; f7 = w[31:25];
      case (op)
         7'h33: return rd < 16 && rs1 < 16 && rs2 < 16 &&
                       (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 7'h01 && f3 < 4));
         7'h13: begin
            if (!(rd < 16 && rs1 < 16)) return 1'b0;
            if (f3 == 1) return f7 == 7'h00;
            if (f3 == 5) return f7 == 7'h00 || f7 == 7'h20;
            return 1'b1;
         end
         7'h03: return f3 == 2 && rs1 == 0 && rd < 16 && f7 == 7'h00;
         7'h23: return f3 == 2 && rs2 == 0 && rs1 < 16 && f7 == 7'h00;
`ifdef QED_INST_GEN_NOP_EN
         7'h7F: return w == 32'h0000_007F;
`endif
         default: return 1'b0;
      endcase
   endfunction

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_lfsr  = 32'h1;
      m_valid = 1'b0;
      m_count = 0;
      exp_q.delete();
   endtask

   task automatic check_a(input string tag);
      check32({tag, ".valid"}, 32'(a_valid), 32'(m_valid));
      check32({tag, ".count"}, 32'(a_count), 32'(m_count));
      check32({tag, ".done"},  32'(a_done),  32'h0);
      check32({tag, ".state"}, 32'(a_state), m_valid ? 32'(ST_ISSUE) : 32'(ST_IDLE));
      if (m_valid) check32({tag, ".inst"}, a_inst, ref_enc(m_lfsr));
   endtask

   // Advance one clock with the currently driven en/out_ready, then compare A.
   task automatic tick(input string tag);
      logic [31:0] w;
      if (m_valid && out_ready) begin
         n_hs++;
         check32({tag, ".legal"}, 32'(legal(a_inst)), 32'h1);
         exp_q.push_back(ref_enc(m_lfsr));
         w = exp_q.pop_front();
         check32({tag, ".xfer"}, a_inst, w);
         if (w == 32'h0000_007F) n_nop++;
         m_count = (m_count == 65535) ? m_count : m_count + 1;
         m_lfsr  = ref_next(m_lfsr);
         m_valid = en;
      end else if (!m_valid && en) begin
         m_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      check_a(tag);
   endtask

   initial begin
      int kb;
      rst = 1'b1; en = 1'b0; out_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_a("reset");
      check32("reset.inst", a_inst, 32'h0200_0033);
      check32("reset.b_done", 32'(b_done), 32'h0);
      check32("reset.c_count", 32'(c_count), 32'h0);
      @(negedge clk);
      rst = 1'b0; en = 1'b1; out_ready = 1'b1;

      // back-to-back issue; B (SEED=0, budget 4) and C (3-bit count) run alongside
      for (int k = 1; k <= 12; k++) begin
         tick("run");
         if (k == 1) check32("first_inst", a_inst, 32'h0200_0033);
         if (k == 2) check32("second_inst", a_inst, 32'h0000_0033);
         if (k == 3) check32("count_after_two", 32'(a_count), 32'd2);
         kb = (k < 2) ? 0 : ((k - 1 > 4) ? 4 : k - 1);
         check32("b.count", 32'(b_count), 32'(kb));
         check32("b.valid", 32'(b_valid), 32'(k <= 4));
         check32("b.done", 32'(b_done), 32'(k >= 5));
         if (k <= 4) check32("b.inst", b_inst, ref_enc(lfsr_n(32'h1, kb)));
         check32("c.count_sat", 32'(c_count), 32'((k - 1 > 7) ? 7 : k - 1));
      end
      check32("b.state_done", 32'(b_state), 32'(ST_DONE));

      // stall with out_ready low; en drops mid-stall
      rst = 1'b1;
      #1;
      check32("rst.b_done_clear", 32'(b_done), 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0; en = 1'b1; out_ready = 1'b0;
      tick("stall_rise");
      for (int i = 0; i < 5; i++) begin
         if (i == 2) en = 1'b0;
         tick("stall");
         check32("stall.inst", a_inst, 32'h0200_0033);
      end
      out_ready = 1'b1;
      tick("stall_release");
      check32("stall.count", 32'(a_count), 32'd1);
      check32("stall.idle", 32'(a_state), 32'(ST_IDLE));

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         en        = ($urandom_range(0, 7) != 0);
         out_ready = $urandom_range(0, 1);
         tick("rand");
      end
`ifdef QED_INST_GEN_NOP_EN
      check32("nop_rate", 32'(n_nop >= n_hs / 64 && n_nop <= n_hs / 8), 32'h1);
`endif

      // reset while a word is pending
      en = 1'b1; out_ready = 1'b0;
      tick("pre_rst");
      tick("pre_rst");
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check_a("mid_rst");
      check32("mid_rst.inst", a_inst, 32'h0200_0033);
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      tick("replay");
      check32("replay.first", a_inst, 32'h0200_0033);
      tick("replay");
      check32("replay.second", a_inst, 32'h0000_0033);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
